// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, Rcon table, GF(2^8) arithmetic,
// S-boxes and whole-state round transforms used by the iterative core.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYGEN,
        ST_READY,
        ST_RUN,
        ST_DONE
    } fsm_t;

    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Multiplicative inverse as a^254 (product of a^(2^k), k = 1..7); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    // S-boxes computed from the field inverse and the affine map instead of a table.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] o;
        for (int k = 0; k < 4; k++) o[8*k +: 8] = sbox(w[8*k +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox(s[8*k +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
        return o;
    endfunction

    // Byte (row r, column c) lives at byte index 4c+r, byte 0 in the MSBs.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        return o;
    endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Key-load, input-block and output-block handshakes of the iterative AES core.
interface aes_iter_core_if #(parameter int NK = 4);

    logic              key_valid;
    logic              key_ready;
    logic [NK*32-1:0]  key_in;
    logic              in_valid;
    logic              in_ready;
    logic              in_decrypt;
    logic [127:0]      in_data;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      out_data;
    logic              out_decrypt;
    logic              busy;

    modport master (
        output key_valid, key_in, in_valid, in_decrypt, in_data, out_ready,
        input  key_ready, in_ready, out_valid, out_data, out_decrypt, busy
    );

    modport slave (
        input  key_valid, key_in, in_valid, in_decrypt, in_data, out_ready,
        output key_ready, in_ready, out_valid, out_data, out_decrypt, busy
    );

endinterface

// File: rtl/aes_key_sched.sv
// Key expansion: copies the cipher key on load, then produces one schedule
// word per cycle into a register store that serves 128-bit round keys.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [NK*32-1:0] key,
    output logic             done,
    input  logic [3:0]       rk_idx,
    output logic [127:0]     rk
);

    localparam int NR = nr_of(NK);
    localparam int NW = 4 * (NR + 1);

    // Kept in registers so a round key is readable in the same cycle it is indexed.
    logic [31:0] w_mem [NW];
    logic [5:0]  idx_reg;
    logic [2:0]  kmod_reg;
    logic [3:0]  rc_reg;
    logic        gen_reg;
    logic [31:0] prev_w;
    logic [31:0] temp_w;
    logic [31:0] new_w;

    // Next schedule word from w[i-1] and w[i-NK]; kmod tracks i mod NK without a divider.
    always_comb begin
        prev_w = w_mem[idx_reg - 6'd1];
        temp_w = prev_w;
        if (kmod_reg == 3'd0)
            temp_w = sub_word(rot_word(prev_w)) ^ {RCON[rc_reg], 24'h000000};
        else if (NK == 8 && kmod_reg == 3'd4)
            temp_w = sub_word(prev_w);
        new_w = w_mem[idx_reg - 6'(NK)] ^ temp_w;
    end

    // Load copies the key and restarts generation; generation stops after the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            gen_reg  <= 1'b0;
            idx_reg  <= '0;
            kmod_reg <= '0;
            rc_reg   <= '0;
        end else if (load) begin
            for (int i = 0; i < NK; i++)
                w_mem[6'(i)] <= key[NK*32-1-32*i -: 32];
            gen_reg  <= 1'b1;
            idx_reg  <= 6'(NK);
            kmod_reg <= '0;
            rc_reg   <= '0;
        end else if (gen_reg) begin
            w_mem[idx_reg] <= new_w;
            idx_reg        <= idx_reg + 6'd1;
            kmod_reg       <= (kmod_reg == 3'(NK - 1)) ? 3'd0 : kmod_reg + 3'd1;
            if (kmod_reg == 3'd0)
                rc_reg <= rc_reg + 4'd1;
            if (idx_reg == 6'(NW - 1))
                gen_reg <= 1'b0;
        end
    end

    assign done = gen_reg && (idx_reg == 6'(NW - 1));
    assign rk   = {w_mem[{rk_idx, 2'd0}], w_mem[{rk_idx, 2'd1}],
                   w_mem[{rk_idx, 2'd2}], w_mem[{rk_idx, 2'd3}]};

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 engine: one round per clock, encrypt or decrypt
// per block, round keys generated once per key load and reused.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic            clk,
    input  logic            reset,
    aes_iter_core_if.slave  bus
);

    localparam int NR = nr_of(NK);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_iter_core: NK must be 4, 6 or 8");
    end

    fsm_t         fsm_reg;
    logic [127:0] state_reg;
    logic [3:0]   round_reg;
    logic         dec_reg;
    logic         key_ready_reg;
    logic         busy_reg;
    logic         out_valid_reg;
    logic         out_decrypt_reg;
    logic [127:0] out_data_reg;
    logic [127:0] round_next;
    logic [127:0] enc_t;
    logic [127:0] dec_t;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         ks_done;
    logic         key_load;
    logic         in_ready_w;
    logic         in_accept;
    logic         last_round;

    assign key_load   = bus.key_valid && key_ready_reg;
    assign in_ready_w = ((fsm_reg == ST_READY) && !bus.key_valid) ||
                        ((fsm_reg == ST_DONE) && bus.out_ready);
    assign in_accept  = bus.in_valid && in_ready_w;
    assign last_round = (round_reg == 4'(NR));

    aes_key_sched #(.NK(NK)) u_key_sched (
        .clk    (clk),
        .reset  (reset),
        .load   (key_load),
        .key    (bus.key_in),
        .done   (ks_done),
        .rk_idx (rk_idx),
        .rk     (rk)
    );

    // Round-key select: the initial whitening key on accept, then rk[r] or rk[NR-r] per round.
    always_comb begin
        if (fsm_reg == ST_RUN)
            rk_idx = dec_reg ? (4'(NR) - round_reg) : round_reg;
        else
            rk_idx = bus.in_decrypt ? 4'(NR) : 4'd0;
    end

    // One cipher round; MixColumns / InvMixColumns are skipped in the final round.
    always_comb begin
        enc_t = shift_rows(sub_bytes(state_reg));
        if (!last_round)
            enc_t = mix_columns(enc_t);
        enc_t = enc_t ^ rk;
        dec_t = inv_sub_bytes(inv_shift_rows(state_reg)) ^ rk;
        if (!last_round)
            dec_t = inv_mix_columns(dec_t);
        round_next = dec_reg ? dec_t : enc_t;
    end

    // Control FSM with registered status outputs; a block accept overrides the DONE exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_reg         <= ST_IDLE;
            state_reg       <= '0;
            round_reg       <= '0;
            dec_reg         <= 1'b0;
            key_ready_reg   <= 1'b1;
            busy_reg        <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_decrypt_reg <= 1'b0;
            out_data_reg    <= '0;
        end else begin
            case (fsm_reg)
                ST_IDLE, ST_READY: begin
                    if (key_load) begin
                        fsm_reg       <= ST_KEYGEN;
                        key_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end
                ST_KEYGEN: begin
                    if (ks_done) begin
                        fsm_reg       <= ST_READY;
                        key_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_reg <= round_next;
                    if (last_round) begin
                        out_data_reg    <= round_next;
                        out_decrypt_reg <= dec_reg;
                        out_valid_reg   <= 1'b1;
                        busy_reg        <= 1'b0;
                        fsm_reg         <= ST_DONE;
                    end else begin
                        round_reg <= round_reg + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        key_ready_reg <= 1'b1;
                        fsm_reg       <= ST_READY;
                    end
                end
                default: fsm_reg <= ST_IDLE;
            endcase

            if (in_accept) begin
                state_reg     <= bus.in_data ^ rk;
                dec_reg       <= bus.in_decrypt;
                round_reg     <= 4'd1;
                key_ready_reg <= 1'b0;
                busy_reg      <= 1'b1;
                fsm_reg       <= ST_RUN;
            end
        end
    end

    assign bus.key_ready   = key_ready_reg;
    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_data    = out_data_reg;
    assign bus.out_decrypt = out_decrypt_reg;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: one instance per key size, shared stimulus
// steered to the instance selected by sel, FIPS-197 / SP800-38A vectors.
module tb_aes_iter_core;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0]   sel;
    logic         key_valid, in_valid, in_decrypt, out_ready;
    logic [255:0] key_in;
    logic [127:0] in_data;
    logic         key_ready, in_ready, out_valid, out_decrypt, busy;
    logic [127:0] out_data;

    localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_iter_core_if #(.NK(4)) b4 ();
    aes_iter_core_if #(.NK(6)) b6 ();
    aes_iter_core_if #(.NK(8)) b8 ();

    assign b4.key_valid  = key_valid && (sel == 2'd0);
    assign b4.key_in     = key_in[255:128];
    assign b4.in_valid   = in_valid && (sel == 2'd0);
    assign b4.in_decrypt = in_decrypt;
    assign b4.in_data    = in_data;
    assign b4.out_ready  = out_ready && (sel == 2'd0);

    assign b6.key_valid  = key_valid && (sel == 2'd1);
    assign b6.key_in     = key_in[255:64];
    assign b6.in_valid   = in_valid && (sel == 2'd1);
    assign b6.in_decrypt = in_decrypt;
    assign b6.in_data    = in_data;
    assign b6.out_ready  = out_ready && (sel == 2'd1);

    assign b8.key_valid  = key_valid && (sel == 2'd2);
    assign b8.key_in     = key_in;
    assign b8.in_valid   = in_valid && (sel == 2'd2);
    assign b8.in_decrypt = in_decrypt;
    assign b8.in_data    = in_data;
    assign b8.out_ready  = out_ready && (sel == 2'd2);

    aes_iter_core #(.NK(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    aes_iter_core #(.NK(6)) dut6 (.clk(clk), .reset(reset), .bus(b6));
    aes_iter_core #(.NK(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));

    always_comb begin
        key_ready = b4.key_ready; in_ready = b4.in_ready; out_valid = b4.out_valid;
        out_data = b4.out_data; out_decrypt = b4.out_decrypt; busy = b4.busy;
        if (sel == 2'd1) begin
            key_ready = b6.key_ready; in_ready = b6.in_ready; out_valid = b6.out_valid;
            out_data = b6.out_data; out_decrypt = b6.out_decrypt; busy = b6.busy;
        end else if (sel == 2'd2) begin
            key_ready = b8.key_ready; in_ready = b8.in_ready; out_valid = b8.out_valid;
            out_data = b8.out_data; out_decrypt = b8.out_decrypt; busy = b8.busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Key handshake, then count cycles with busy high (bounded).
    task automatic load_key(input logic [255:0] k, output int gen_cycles);
        @(negedge clk);
        key_valid = 1'b1;
        key_in    = k;
        @(negedge clk);
        key_valid  = 1'b0;
        gen_cycles = 0;
        while (busy && gen_cycles < 200) begin
            gen_cycles++;
            @(negedge clk);
        end
        $display("key load key=%h keygen_cycles=%0d", k, gen_cycles);
    endtask

    // One block from READY: accept, wait for out_valid (bounded), then take the result.
    task automatic run_block(input logic dec, input logic [127:0] d,
                             output logic [127:0] res, output logic res_dec, output int lat);
        @(negedge clk);
        in_valid   = 1'b1;
        in_decrypt = dec;
        in_data    = d;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res     = out_data;
        res_dec = out_decrypt;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        $display("block dec=%0b in=%h out=%h out_dec=%0b latency=%0d", dec, d, res, res_dec, lat);
    endtask

    task automatic test_reset();
        bit bad;
        sel = 2'd0;
        in_valid = 1'b1;
        in_data = PT;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_decrypt !== 1'b0) begin errors++; $display("FAIL reset_out_decrypt got %b want 0", out_decrypt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b want 1", key_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        bad = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL idle_block_ignored in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); end
        in_valid = 1'b0;
        $display("reset test done");
    endtask

    task automatic test_kat(input logic [1:0] s, input logic [255:0] k, input logic [127:0] ct,
                            input int exp_gen, input int exp_lat);
        int gen, lat;
        logic [127:0] res;
        logic rdec;
        sel = s;
        load_key(k, gen);
        checks++; if (gen != exp_gen) begin errors++; $display("FAIL keygen_cycles sel=%0d got %0d want %0d", s, gen, exp_gen); end
        run_block(1'b0, PT, res, rdec, lat);
        checks++; if (res !== ct) begin errors++; $display("FAIL encrypt sel=%0d got %h want %h", s, res, ct); end
        checks++; if (rdec !== 1'b0) begin errors++; $display("FAIL encrypt_mode sel=%0d got %b want 0", s, rdec); end
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL encrypt_latency sel=%0d got %0d want %0d", s, lat, exp_lat); end
        run_block(1'b1, ct, res, rdec, lat);
        checks++; if (res !== PT) begin errors++; $display("FAIL decrypt sel=%0d got %h want %h", s, res, PT); end
        checks++; if (rdec !== 1'b1) begin errors++; $display("FAIL decrypt_mode sel=%0d got %b want 1", s, rdec); end
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL decrypt_latency sel=%0d got %0d want %0d", s, lat, exp_lat); end
    endtask

    task automatic test_back_to_back();
        int wait_cnt, lat;
        bit bad;
        sel = 2'd0;
        @(negedge clk);
        in_valid = 1'b1; in_decrypt = 1'b0; in_data = PT;
        @(negedge clk);
        // second block offered while the first is still running; must be ignored until DONE
        in_decrypt = 1'b1; in_data = CT128;
        wait_cnt = 1;
        bad = 0;
        while (!out_valid && wait_cnt < 100) begin
            #1; if (in_ready !== 1'b0) bad = 1;
            @(negedge clk);
            wait_cnt++;
        end
        checks++; if (bad) begin errors++; $display("FAIL run_in_ready got 1 want 0"); end
        checks++; if (wait_cnt != 11) begin errors++; $display("FAIL b2b_first_latency got %0d want 11", wait_cnt); end
        bad = 0;
        repeat (20) begin
            #1;
            if (out_valid !== 1'b1 || out_data !== CT128 || out_decrypt !== 1'b0 || in_ready !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++; if (bad) begin errors++; $display("FAIL backpressure_hold out_valid=%b out_data=%h in_ready=%b want 1/%h/0", out_valid, out_data, in_ready, CT128); end
        $display("block dec=0 in=%h out=%h held 20 cycles", PT, out_data);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL done_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept out_valid=%b busy=%b want 0/1", out_valid, busy); end
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 11) begin errors++; $display("FAIL b2b_second_latency got %0d want 11", lat); end
        checks++; if (out_data !== PT || out_decrypt !== 1'b1) begin errors++; $display("FAIL b2b_second_result got %h/%b want %h/1", out_data, out_decrypt, PT); end
        $display("block dec=1 in=%h out=%h latency=%0d", CT128, out_data, lat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_collision_rekey();
        int gen, lat;
        bit bad;
        logic [127:0] res;
        logic rdec;
        sel = 2'd0;
        @(negedge clk);
        key_valid = 1'b1; key_in = KEY_B;
        in_valid = 1'b1; in_decrypt = 1'b0; in_data = PT_B;
        #1;
        checks++; if (in_ready !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL collision_ready in_ready=%b key_ready=%b want 0/1", in_ready, key_ready); end
        @(negedge clk);
        key_valid = 1'b0;
        gen = 0;
        bad = 0;
        while (busy && gen < 200) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || key_ready !== 1'b0) bad = 1;
            gen++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (bad) begin errors++; $display("FAIL keygen_block_ignored in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); end
        checks++; if (gen != 40) begin errors++; $display("FAIL rekey_keygen_cycles got %0d want 40", gen); end
        $display("key load key=%h keygen_cycles=%0d (collision)", KEY_B, gen);
        run_block(1'b0, PT_B, res, rdec, lat);
        checks++; if (res !== CT_B) begin errors++; $display("FAIL rekey_encrypt got %h want %h", res, CT_B); end
        checks++; if (lat != 11) begin errors++; $display("FAIL rekey_latency got %0d want 11", lat); end
    endtask

    task automatic test_reset_mid_run();
        bit bad;
        sel = 2'd0;
        @(negedge clk);
        in_valid = 1'b1; in_decrypt = 1'b0; in_data = PT;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL midrun_out_data got %h want 0", out_data); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL midrun_key_ready got %b want 1", key_ready); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrun_in_ready_busy got %b/%b want 0/0", in_ready, busy); end
        in_valid = 1'b1; in_data = PT;
        bad = 0;
        repeat (30) begin
            @(negedge clk); #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        in_valid = 1'b0;
        checks++; if (bad) begin errors++; $display("FAIL no_key_block_accepted in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); end
        $display("reset mid-run done");
    endtask

    initial begin
        sel = 2'd0;
        key_valid = 1'b0; key_in = '0;
        in_valid = 1'b0; in_decrypt = 1'b0; in_data = '0;
        out_ready = 1'b0;
        test_reset();
        test_kat(2'd0, KEY128, CT128, 40, 11);
        test_kat(2'd1, KEY192, CT192, 46, 13);
        test_kat(2'd2, KEY256, CT256, 52, 15);
        test_back_to_back();
        test_collision_rekey();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
